// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution job controller.
// Contents: controller state encoding, coefficient count, default
// coefficient width and the coefficient index width.
package conv_ctrl_pkg;

    localparam int unsigned NUM_COEF       = 9;
    localparam int unsigned COEF_W_DEFAULT = 16;
    // Index must hold 0..NUM_COEF (it reaches NUM_COEF after the last beat).
    localparam int unsigned IDX_W          = $clog2(NUM_COEF + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/conv_job_ctrl_if.sv
// Host/processor-facing bus of the convolution job controller.
// slave  : controller side (takes job/coef/status inputs, drives
//          coef_ready, ld, k1..k9, cpu_rst, busy/done/err, cycle_cnt).
// master : host/processor side (mirror of slave).
interface conv_job_ctrl_if import conv_ctrl_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DEFAULT,
    parameter int unsigned CNT_W  = 32
) ();

    logic              start;
    logic              abort;
    logic              coef_valid;
    logic [COEF_W-1:0] coef_data;
    logic              coef_ready;
    logic              complete;
    logic              ack;
    logic              ld;
    logic [COEF_W-1:0] k1, k2, k3, k4, k5, k6, k7, k8, k9;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  cycle_cnt;

    modport slave (
        input  start, abort, coef_valid, coef_data, complete, ack,
        output coef_ready, ld, k1, k2, k3, k4, k5, k6, k7, k8, k9,
               cpu_rst, busy, done, err, cycle_cnt
    );

    modport master (
        output start, abort, coef_valid, coef_data, complete, ack,
        input  coef_ready, ld, k1, k2, k3, k4, k5, k6, k7, k8, k9,
               cpu_rst, busy, done, err, cycle_cnt
    );

endinterface

// File: rtl/conv_coef_bank.sv
// Nine-entry kernel coefficient register bank.
// Ports: clk_i, rst_ni (async, active-low), we_i (write enable),
//        idx_i (entry index, 0 = k1), data_i (write value),
//        k_o (current register contents, k_o[0] = k1).
// Out-of-range indices are ignored.
module conv_coef_bank import conv_ctrl_pkg::*; #(
    parameter int unsigned COEF_W = COEF_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [COEF_W-1:0] data_i,
    output logic [COEF_W-1:0] k_o [NUM_COEF]
);

    logic [COEF_W-1:0] k_q [NUM_COEF];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
                k_q[i] <= '0;
            end
        end else if (we_i && (idx_i < IDX_W'(NUM_COEF))) begin
            k_q[idx_i] <= data_i;
        end
    end

    assign k_o = k_q;

endmodule

// File: rtl/conv_job_ctrl.sv
// Convolution job controller: loads nine kernel coefficients from a
// valid/ready stream, holds the processor in reset while strobing ld for
// two cycles, releases it for the run phase and reports done/err.
// Ports: clk (rising edge), rst (async, active-low), bus (slave modport
//        of conv_job_ctrl_if carrying all job, coefficient and status signals).
// Optional feature: define CONV_WDOG_EN to enable the run-phase watchdog
// (RUN -> ERR once cycle_cnt reaches WDOG_LIMIT). Without it err is 0.
module conv_job_ctrl import conv_ctrl_pkg::*; #(
    parameter int unsigned COEF_W     = COEF_W_DEFAULT,
    parameter int unsigned CNT_W      = 32,
    parameter logic [31:0] WDOG_LIMIT = 32'd4_000_000
) (
    input logic             clk,
    input logic             rst,
    conv_job_ctrl_if.slave  bus
);

`ifdef CONV_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              arm_q, arm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              wdog_hit;
    logic              coef_we;
    logic              coef_ready, ld, cpu_rst, busy, done, err_st;
    logic [COEF_W-1:0] k [NUM_COEF];

    // Saturating increment; the watchdog looks at the value this RUN cycle
    // will leave behind so the trip lands on run cycle WDOG_LIMIT.
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign wdog_hit = (cnt_inc >= CNT_W'(WDOG_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        arm_d      = 1'b0;
        cnt_d      = cnt_q;
        coef_we    = 1'b0;
        coef_ready = 1'b0;
        ld         = 1'b0;
        cpu_rst    = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        err_st     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                // Ready drops during abort so an abort cycle never counts as a beat.
                coef_ready = !bus.abort;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (bus.coef_valid) begin
                    coef_we = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_COEF - 1)) begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                busy = 1'b1;
                ld   = 1'b1;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    arm_d = !arm_q;
                    if (arm_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
                cnt_d   = cnt_inc;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (bus.complete) begin
                    state_d = ST_DONE;
                end else if (WDOG_EN && wdog_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                err_st = 1'b1;
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    conv_coef_bank #(
        .COEF_W (COEF_W)
    ) u_bank (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (coef_we),
        .idx_i  (idx_q),
        .data_i (bus.coef_data),
        .k_o    (k)
    );

    assign bus.coef_ready = coef_ready;
    assign bus.ld         = ld;
    assign bus.cpu_rst    = cpu_rst;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = WDOG_EN & err_st;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.k1         = k[0];
    assign bus.k2         = k[1];
    assign bus.k3         = k[2];
    assign bus.k4         = k[3];
    assign bus.k5         = k[4];
    assign bus.k6         = k[5];
    assign bus.k7         = k[6];
    assign bus.k8         = k[7];
    assign bus.k9         = k[8];

endmodule

// File: doc/conv_job_ctrl.md
CONV_JOB_CTRL -- requirements
Module: conv_job_ctrl

Interface
REQ-001 Parameter COEF_W, default 16, kernel coefficient width.
REQ-002 Parameter CNT_W, default 32, run-cycle counter width.
REQ-003 Parameter WDOG_LIMIT, default 32'd4_000_000, run cycles before timeout.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle job request.
REQ-007 abort  in  1  cancel the current job.
REQ-008 coef_valid  in  1  coefficient beat valid.
REQ-009 coef_data  in  COEF_W  coefficient value, k1 first, k9 last.
REQ-010 coef_ready  out  1  controller accepts a coefficient beat.
REQ-011 complete  in  1  processor program-finished flag.
REQ-012 ack  in  1  host acknowledges done or err.
REQ-013 ld  out  1  coefficient-load strobe to the processor instruction store.
REQ-014 k1..k9  out  COEF_W each  registered kernel coefficients.
REQ-015 cpu_rst  out  1  processor reset, active-high.
REQ-016 busy, done, err  out  1 each  job status flags.
REQ-017 cycle_cnt  out  CNT_W  run-phase cycle count.

Function
REQ-018 The state machine SHALL use the states IDLE, LOAD, ARM, RUN, DONE and ERR.
REQ-019 IDLE: a sampled start SHALL move to LOAD and clear idx to 0, cycle_cnt, done and err; coef_valid is ignored in IDLE.
REQ-020 LOAD: coef_ready SHALL be 1; each valid&ready beat writes k[idx+1] and increments idx; the 9th beat moves to ARM on the next cycle.
REQ-021 ARM: ld SHALL be 1 for exactly 2 cycles with cpu_rst=1, then the controller moves to RUN.
REQ-022 RUN: cpu_rst=0 and ld=0; cycle_cnt SHALL increment every cycle and saturate at all-ones.
REQ-023 RUN: complete=1 SHALL move the controller to DONE on the next edge.
REQ-024 DONE: done=1 and cpu_rst=1; ack SHALL move to IDLE.
REQ-025 ERR: err=1 and cpu_rst=1; ack SHALL move to IDLE.
REQ-026 busy SHALL be 1 in LOAD, ARM and RUN only.
REQ-027 cpu_rst SHALL be 1 in every state except RUN.
REQ-028 start outside IDLE, and complete outside RUN, SHALL be ignored.
REQ-029 abort in LOAD, ARM or RUN SHALL move to IDLE next cycle; k1..k9 are kept, idx is cleared, and no done or err is raised.
REQ-030 abort and complete together in RUN: abort SHALL win.
REQ-031 k1..k9 SHALL change only on LOAD write beats.
REQ-032 Latency: exactly 9 accepted beats, then 2 ARM cycles, then the first RUN cycle.

Reset
REQ-033 Asserting rst SHALL force, asynchronously and at any time (including mid-job): state=IDLE, idx=0, k1..k9=0, ld=0, coef_ready=0, cpu_rst=1, busy=0, done=0, err=0, cycle_cnt=0.

Configuration
REQ-034 With CONV_WDOG_EN defined, cycle_cnt reaching WDOG_LIMIT in RUN SHALL move to ERR; complete in that same cycle SHALL win and move to DONE instead.
REQ-035 Without CONV_WDOG_EN, RUN SHALL leave only on complete or abort, err SHALL be tied to 0, and ERR SHALL be unreachable.

Structure
REQ-036 Package conv_ctrl_pkg SHALL hold the state enum, NUM_COEF=9 and the default COEF_W.
REQ-037 Sub-module conv_coef_bank SHALL hold the nine registers, with write-enable, index and data inputs.

Verification
REQ-038 Reset, start, 9 beats 1..9, complete at run cycle 100 -> k1..k9=1..9; ld high for 2 cycles; done=1; cycle_cnt=100; ack -> IDLE.
REQ-039 coef_valid toggling 1,0,1 during LOAD -> only valid beats written; ARM entered after the 9th accepted beat.
REQ-040 start and complete pulsed in IDLE and DONE -> no state change; busy=0.
REQ-041 abort after 4 beats, then a new job -> idx restarts; k1..k9 end as the new job's values.
REQ-042 CONV_WDOG_EN with WDOG_LIMIT=50 and no complete -> err=1 at run cycle 50; complete on that same cycle -> done=1 instead.
REQ-043 rst low mid-RUN -> all outputs take their reset values immediately, without waiting for a clock edge.
